// File: rtl/conv_window_builder.sv
// Buffers one raster-order frame, then streams every 3x3 window of it with the
// stride and zero padding captured at start. Each window is packed as 9 pixels.
module conv_window_builder #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         stride,
  input  logic [1:0]         padding,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic               win_last,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int NPIX    = IMG_W * IMG_H;
  localparam int AW      = $clog2(NPIX);
  localparam int IMG_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int OW      = $clog2(IMG_MAX + 3);
  // Signed coordinate width: covers -2 .. (IMG_MAX+2)*3 with headroom.
  localparam int CW      = $clog2(3 * (IMG_MAX + 4) + 1) + 1;
  localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_W);
  localparam logic signed [CW-1:0] IMG_H_S = CW'(IMG_H);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]       s_q, p_q, s_eff, p_eff;
  logic [AW-1:0]    pix_cnt;
  logic [OW-1:0]    ox, oy, ox_last, oy_last;
  logic [PIX_W-1:0] mem [NPIX];

  logic beat, fire, load_end, at_row_end, at_end;
  logic signed [CW-1:0] base_y, base_x;

  // Index of the last window along one axis: floor((img + 2p - 3) / s).
  function automatic logic [OW-1:0] last_idx(input int img, input logic [1:0] s,
                                             input logic [1:0] p);
    int n;
    n = img + 2 * int'(p) - 3;
    case (s)
      2'd2:    n = n / 2;
      2'd3:    n = n / 3;
      default: n = n;
    endcase
    return OW'(n);
  endfunction

  assign s_eff = (stride == 2'd0) ? 2'd1 : stride;
  assign p_eff = (padding == 2'd3) ? 2'd2 : padding;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; win_valid/win_data/win_last are held unchanged until that transfer.
  assign in_ready  = (state == LOAD);
  assign win_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  assign beat       = in_valid && in_ready;
  assign fire       = win_valid && win_ready;
  assign load_end   = beat && (pix_cnt == AW'(NPIX - 1));
  assign at_row_end = (ox == ox_last);
  assign at_end     = at_row_end && (oy == oy_last);
  assign win_last   = win_valid && at_end;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (load_end) state_nxt = EMIT;
      EMIT:    if (fire && at_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_q     <= 2'd1;
      p_q     <= '0;
      pix_cnt <= '0;
      ox      <= '0;
      oy      <= '0;
      ox_last <= '0;
      oy_last <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        s_q     <= s_eff;
        p_q     <= p_eff;
        pix_cnt <= '0;
        ox_last <= last_idx(IMG_W, s_eff, p_eff);
        oy_last <= last_idx(IMG_H, s_eff, p_eff);
      end
      if (beat) pix_cnt <= pix_cnt + 1'b1;
      if (load_end) begin
        ox <= '0;
        oy <= '0;
      end
      if (fire) begin
        if (at_row_end) begin
          ox <= '0;
          if (!at_end) oy <= oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end

  // Frame store holds pixel data only; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (beat) mem[pix_cnt] <= in_data;
  end

  assign base_y = $signed({{(CW-OW){1'b0}}, oy}) * $signed({{(CW-2){1'b0}}, s_q})
                - $signed({{(CW-2){1'b0}}, p_q});
  assign base_x = $signed({{(CW-OW){1'b0}}, ox}) * $signed({{(CW-2){1'b0}}, s_q})
                - $signed({{(CW-2){1'b0}}, p_q});

  for (genvar k = 0; k < 9; k++) begin : g_win
    localparam logic signed [CW-1:0] ROFF = CW'(k / 3);
    localparam logic signed [CW-1:0] COFF = CW'(k % 3);
    logic signed [CW-1:0] wy, wx;
    logic                 in_rng;
    logic [AW-1:0]        addr;

    assign wy     = base_y + ROFF;
    assign wx     = base_x + COFF;
    assign in_rng = !wy[CW-1] && (wy < IMG_H_S) && !wx[CW-1] && (wx < IMG_W_S);
    // Out-of-frame taps use address 0 and are zeroed, so the store is never
    // indexed with a negative or overflowing coordinate.
    assign addr   = in_rng ? AW'(32'(wy) * IMG_W + 32'(wx)) : '0;
    assign win_data[k*PIX_W +: PIX_W] = in_rng ? mem[addr] : '0;
  end

endmodule
